spi_bus_ctrl: RTL and testbench

Transaction sequencer between `spi_data_path` and the accelerator's internal register/memory bus. It detects the address and data phases reported by `spi_data_path` and decodes the latched status nibble. It then issues single-word read or write requests on a req/ack bus and returns read data on the `rdata` input of `spi_data_path`. Burst mode auto-increments the address, and every bus access is guarded by a timeout.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_bus_ctrl_edge_det.sv | 24 ++
 rtl/spi_bus_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI-to-bus transaction sequencer: FSM encoding,
// status field bit positions and the fill value returned on a failed read.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DONE = 3'd2,
    WR_WAIT = 3'd3,
    WR_REQ  = 3'd4
  } state_t;

  localparam int ST_WR    = 2;
  localparam int ST_BURST = 1;

  // Replicated across the data width when a read times out.
  localparam logic RD_ERR_FILL = 1'b1;

endpackage

// File: rtl/spi_bus_ctrl_edge_det.sv
// Registered rising-edge detector: one-cycle pulse the cycle after level rises.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev_reg;
  logic pulse_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      prev_reg  <= level;
      pulse_reg <= level & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/spi_bus_ctrl.sv
// Sequences single-word bus reads/writes from SPI address/data phase events,
// with burst auto-increment, a per-access timeout and chip-select abort.
module spi_bus_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              address_ready,
  input  logic              data_ready,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [3:0]        status_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  logic [1:0] lvl;
  logic [1:0] evt;
  logic       ap;
  logic       dp;

  assign lvl = {data_ready, address_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    edge_det u_edge (
      .clk   (clk),
      .reset (reset),
      .level (lvl[gi]),
      .pulse (evt[gi])
    );
  end

  assign ap = evt[0];
  assign dp = evt[1];

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cur_addr_reg, cur_addr_next;
  logic [3:0]        cur_stat_reg, cur_stat_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              err_reg, err_next;
  logic [9:0]        cnt_reg, cnt_next;
  logic              req_reg, we_reg, busy_reg;

  always_comb begin
    state_next    = state_reg;
    cur_addr_next = cur_addr_reg;
    cur_stat_next = cur_stat_reg;
    rdata_next    = rdata_reg;
    wdata_next    = wdata_reg;
    err_next      = err_reg;
    cnt_next      = 10'd0;
    case (state_reg)
      IDLE: begin
        if (ap && !cs_n) begin
          cur_addr_next = addr_in;
          cur_stat_next = status_in;
          err_next      = 1'b0;
          state_next    = status_in[ST_WR] ? WR_WAIT : RD_REQ;
        end
      end
      RD_REQ: begin
        // An ack wins over a simultaneous data phase, which is dropped.
        if (bus_ack) begin
          rdata_next = bus_rdata;
          state_next = RD_DONE;
        end else if (cnt_reg == TO_LAST) begin
          rdata_next = {DATA_W{RD_ERR_FILL}};
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      RD_DONE: begin
        if (dp) begin
          if (cur_stat_reg[ST_BURST]) begin
            cur_addr_next = cur_addr_reg + 1'b1;
            state_next    = RD_REQ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      WR_WAIT: begin
        if (dp) begin
          wdata_next = wdata_in;
          state_next = WR_REQ;
        end
      end
      WR_REQ: begin
        if (bus_ack) begin
          if (cur_stat_reg[ST_BURST]) begin
            cur_addr_next = cur_addr_reg + 1'b1;
            state_next    = WR_WAIT;
          end else begin
            state_next = IDLE;
          end
        end else if (cnt_reg == TO_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 10'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort keeps err and spi_rdata, except that an ack landing now still delivers its data.
    if (cs_n) begin
      state_next = IDLE;
      err_next   = err_reg;
      if (!(state_reg == RD_REQ && bus_ack)) begin
        rdata_next = rdata_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_addr_reg <= '0;
      cur_stat_reg <= '0;
      rdata_reg    <= '0;
      wdata_reg    <= '0;
      err_reg      <= 1'b0;
      cnt_reg      <= 10'd0;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_addr_reg <= cur_addr_next;
      cur_stat_reg <= cur_stat_next;
      rdata_reg    <= rdata_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      req_reg      <= (state_next == RD_REQ) || (state_next == WR_REQ);
      we_reg       <= (state_next == WR_REQ);
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign spi_rdata = rdata_reg;
  assign bus_req   = req_reg;
  assign bus_we    = we_reg;
  assign bus_addr  = cur_addr_reg;
  assign bus_wdata = wdata_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Directed bench for spi_bus_ctrl: read, write, wrapping burst, timeout,
// abort, reset mid-access and long address_ready levels.
module tb_spi_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1;
  logic        address_ready = 1'b0;
  logic        data_ready = 1'b0;
  logic [19:0] addr_in = '0;
  logic [3:0]  status_in = '0;
  logic [15:0] wdata_in = '0;
  logic [15:0] spi_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [19:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = 16'hBEEF;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int ack_delay = 3;
  int hold = 0;
  int req_hi_cycles = 0;
  int req_rises = 0;
  logic req_q = 1'b0;
  logic [35:0] wr_q[$];
  int n;

  spi_bus_ctrl #(.ADDR_W(20), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs_n          (cs_n),
    .address_ready (address_ready),
    .data_ready    (data_ready),
    .addr_in       (addr_in),
    .status_in     (status_in),
    .wdata_in      (wdata_in),
    .spi_rdata     (spi_rdata),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  // Bus slave: acks after ack_delay request cycles; negative delay never acks.
  always @(posedge clk) begin
    #1;
    if (bus_req) begin
      bus_ack = (ack_delay >= 0) && (hold == ack_delay);
      hold++;
    end else begin
      bus_ack = 1'b0;
      hold = 0;
    end
  end

  always @(negedge clk) begin
    if (bus_req) req_hi_cycles++;
    if (bus_req && !req_q) req_rises++;
    req_q = bus_req;
    if (bus_req && bus_ack) begin
      if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
      $display("bus %s addr=%05h wdata=%04h rdata=%04h", bus_we ? "WR" : "RD",
               bus_addr, bus_wdata, bus_rdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ack(input string tag, output int cycles);
    cycles = 0;
    while (!bus_ack && cycles < 20) begin
      tick();
      cycles++;
    end
    check(tag, bus_ack, 1);
    tick();
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_rdata", spi_rdata, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);

    // Single read; ack three cycles after the request appears.
    cs_n = 1'b0;
    addr_in = 20'h00123;
    status_in = 4'b0000;
    ack_delay = 3;
    address_ready = 1'b1;
    tick();
    check("rd_req_early", bus_req, 0);
    tick();
    check("rd_req_lat", bus_req, 1);
    check("rd_addr", bus_addr, 20'h00123);
    check("rd_we", bus_we, 0);
    address_ready = 1'b0;
    wait_ack("rd_ack", n);
    check("rd_ack_wait", n, 3);
    check("rd_data", spi_rdata, 16'hBEEF);
    check("rd_req_drop", bus_req, 0);
    // Margin: rise to rdata valid is 2 + 3 + 1 cycles.
    check("rd_margin", 2 + n + 1, 6);
    data_ready = 1'b1;
    tick();
    check("rd_done_busy", busy, 1);
    tick();
    check("rd_idle", busy, 0);
    data_ready = 1'b0;

    // Single write.
    wr_q.delete();
    status_in = 4'b0100;
    addr_in = 20'h00040;
    address_ready = 1'b1;
    tick();
    tick();
    address_ready = 1'b0;
    check("wr_wait_busy", busy, 1);
    check("wr_wait_req", bus_req, 0);
    wdata_in = 16'hA5A5;
    data_ready = 1'b1;
    tick();
    tick();
    data_ready = 1'b0;
    check("wr_we", bus_we, 1);
    check("wr_wdata", bus_wdata, 16'hA5A5);
    wait_ack("wr_ack", n);
    check("wr_idle", busy, 0);
    repeat (3) tick();
    check("wr_count", wr_q.size(), 1);
    check("wr_entry", wr_q[0], {20'h00040, 16'hA5A5});

    // Burst write of three words with zero-wait acks, wrapping the address.
    wr_q.delete();
    ack_delay = 0;
    status_in = 4'b0110;
    addr_in = 20'hFFFFF;
    address_ready = 1'b1;
    tick();
    tick();
    address_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wdata_in = 16'h1000 + 16'(w);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      repeat (4) tick();
    end
    check("bw_count", wr_q.size(), 3);
    check("bw_w0", wr_q[0], {20'hFFFFF, 16'h1000});
    check("bw_w1", wr_q[1], {20'h00000, 16'h1001});
    check("bw_w2", wr_q[2], {20'h00001, 16'h1002});
    check("bw_stay", busy, 1);
    cs_n = 1'b1;
    tick();
    check("bw_abort_busy", busy, 0);
    cs_n = 1'b0;

    // Abort during WR_REQ with a bus that never acks.
    ack_delay = -1;
    status_in = 4'b0100;
    addr_in = 20'h00055;
    address_ready = 1'b1;
    tick();
    tick();
    address_ready = 1'b0;
    wdata_in = 16'h1234;
    data_ready = 1'b1;
    tick();
    tick();
    data_ready = 1'b0;
    check("ab_req_on", bus_req, 1);
    cs_n = 1'b1;
    tick();
    check("ab_req_off", bus_req, 0);
    check("ab_busy", busy, 0);
    check("ab_err", err, 0);
    cs_n = 1'b0;
    tick();

    // Timeout on a read: request lasts exactly TIMEOUT cycles.
    status_in = 4'b0000;
    addr_in = 20'h00200;
    address_ready = 1'b1;
    tick();
    req_hi_cycles = 0;
    tick();
    address_ready = 1'b0;
    repeat (12) tick();
    check("to_req_cycles", req_hi_cycles, 8);
    check("to_err", err, 1);
    check("to_rdata", spi_rdata, 16'hFFFF);
    check("to_busy", busy, 0);

    // The next address phase clears err; reset lands while in RD_REQ.
    ack_delay = 3;
    addr_in = 20'h00300;
    address_ready = 1'b1;
    tick();
    tick();
    address_ready = 1'b0;
    check("clr_err", err, 0);
    check("clr_req", bus_req, 1);
    reset = 1'b1;
    tick();
    check("rr_req", bus_req, 0);
    check("rr_rdata", spi_rdata, 0);
    check("rr_wdata", bus_wdata, 0);
    check("rr_addr", bus_addr, 0);
    check("rr_busy", busy, 0);
    reset = 1'b0;
    tick();

    // address_ready held high for ten cycles gives a single request.
    ack_delay = 2;
    addr_in = 20'h00010;
    req_rises = 0;
    address_ready = 1'b1;
    repeat (10) tick();
    address_ready = 1'b0;
    repeat (3) tick();
    check("lvl_req_count", req_rises, 1);
    check("lvl_rdata", spi_rdata, 16'hBEEF);
    data_ready = 1'b1;
    tick();
    tick();
    data_ready = 1'b0;
    check("lvl_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
